dmx_frame_ctrl: RTL and testbench

DMX_FRAME_CTRL -- requirements
Module: dmx_frame_ctrl

---
 rtl/dmx_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmx_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_frame_ctrl.sv
// ============================================================================
// dmx_frame_ctrl: DMX512 receive framing, double-buffered slot store, publish.
// Optional macro DMX_ALT_START_EN accepts any start code.  Rev 1.0
// ============================================================================
`default_nettype none

module dmx_frame_ctrl #(
  parameter int MAX_SLOTS = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brk_det,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_ferr,
  input  logic       frame_ack,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_bank,
  output logic       frame_valid,
  output logic [9:0] frame_len,
  output logic [7:0] frame_sc,
  output logic [7:0] overrun_cnt
);

  localparam logic [9:0] C_MAX_SLOTS = 10'(MAX_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_SLOTS   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t     state_q;
  logic [9:0] slot_cnt_q;
  logic [7:0] sc_q;
  logic       wr_en_q;
  logic [9:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       rd_bank_q;
  logic       frame_valid_q;
  logic [9:0] frame_len_q;
  logic [7:0] frame_sc_q;
  logic [7:0] overrun_cnt_q;

  logic       w_sc_ok;
  logic [7:0] w_sc_val;
  logic       w_commit;
  logic       w_held;
  logic       w_room;
  logic [7:0] overrun_cnt_d;

`ifdef DMX_ALT_START_EN
  assign w_sc_ok  = 1'b1;
  assign w_sc_val = rx_data;
`else
  assign w_sc_ok  = (rx_data == 8'h00);
  assign w_sc_val = 8'h00;
`endif

  // A same-cycle ack frees the published bank before the commit looks at it.
  assign w_held   = frame_valid_q && !frame_ack;
  assign w_commit = (state_q == ST_SLOTS) && (brk_det || (rx_valid && rx_ferr));
  assign w_room   = (slot_cnt_q < C_MAX_SLOTS);
  assign overrun_cnt_d = (overrun_cnt_q == 8'hFF) ? overrun_cnt_q : overrun_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      slot_cnt_q    <= 10'd0;
      sc_q          <= 8'h00;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 10'd0;
      wr_data_q     <= 8'h00;
      rd_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 10'd0;
      frame_sc_q    <= 8'h00;
      overrun_cnt_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;

      if (frame_ack && frame_valid_q) begin
        frame_valid_q <= 1'b0;
      end

      if (w_commit) begin
        if (!w_held) begin
          rd_bank_q     <= ~rd_bank_q;
          frame_len_q   <= slot_cnt_q;
          frame_sc_q    <= sc_q;
          frame_valid_q <= 1'b1;
        end else begin
          overrun_cnt_q <= overrun_cnt_d;
        end
      end

      if (brk_det) begin
        state_q    <= ST_START;
        slot_cnt_q <= 10'd0;
      end else begin
        case (state_q)
          ST_START: begin
            if (rx_valid) begin
              if (rx_ferr) begin
                state_q <= ST_IDLE;
              end else if (w_sc_ok) begin
                state_q <= ST_SLOTS;
                sc_q    <= w_sc_val;
              end else begin
                state_q <= ST_DISCARD;
              end
            end
          end
          ST_SLOTS: begin
            if (rx_valid) begin
              if (rx_ferr) begin
                state_q <= ST_IDLE;
              end else if (w_room) begin
                wr_en_q    <= 1'b1;
                wr_addr_q  <= {~rd_bank_q, slot_cnt_q[8:0]};
                wr_data_q  <= rx_data;
                slot_cnt_q <= slot_cnt_q + 10'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign frame_sc    = frame_sc_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dmx_frame_ctrl.sv
// ============================================================================
// tb_dmx_frame_ctrl: directed vector table plus corner-case sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmx_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       brk_det;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       frame_ack;

  logic       wr_en,   wr_en8;
  logic [9:0] wr_addr, wr_addr8;
  logic [7:0] wr_data, wr_data8;
  logic       rd_bank, rd_bank8;
  logic       fv,      fv8;
  logic [9:0] flen,    flen8;
  logic [7:0] fsc,     fsc8;
  logic [7:0] ovr,     ovr8;

  dmx_frame_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .brk_det(brk_det), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ferr(rx_ferr), .frame_ack(frame_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
    .frame_valid(fv), .frame_len(flen), .frame_sc(fsc), .overrun_cnt(ovr)
  );

  dmx_frame_ctrl #(.MAX_SLOTS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .brk_det(brk_det), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ferr(rx_ferr), .frame_ack(frame_ack),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8), .rd_bank(rd_bank8),
    .frame_valid(fv8), .frame_len(flen8), .frame_sc(fsc8), .overrun_cnt(ovr8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       brk, rxv;
    logic [7:0] d;
    logic       ferr, ack;
    logic       wen;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       rb, fv;
    logic [9:0] len;
    logic [7:0] sc, ov;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       e_rb, e_fv;
  logic [9:0] e_len;
  logic [7:0] e_sc, e_ov;

`ifdef DMX_ALT_START_EN
  localparam logic C_ALT = 1'b1;
`else
  localparam logic C_ALT = 1'b0;
`endif

  function automatic void push(input logic brk, input logic rxv, input logic [7:0] d,
                               input logic ferr, input logic ack, input logic wen,
                               input logic [9:0] wa, input logic [7:0] wd);
    vec_t v;
    v.brk = brk; v.rxv = rxv; v.d = d; v.ferr = ferr; v.ack = ack;
    v.wen = wen; v.wa = wa; v.wd = wd;
    v.rb = e_rb; v.fv = e_fv; v.len = e_len; v.sc = e_sc; v.ov = e_ov;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic brk, input logic rxv, input logic [7:0] d,
                       input logic ferr, input logic ack);
    brk_det = brk; rx_valid = rxv; rx_data = d; rx_ferr = ferr; frame_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write address/data only matter while the strobe is expected high.
  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = (wr_en === v.wen) && (rd_bank === v.rb) && (fv === v.fv) &&
         (flen === v.len) && (fsc === v.sc) && (ovr === v.ov);
    if (v.wen) ok = ok && (wr_addr === v.wa) && (wr_data === v.wd);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got wen=%b wa=%h wd=%h rb=%b fv=%b len=%0d sc=%h ov=%0d expected wen=%b wa=%h wd=%h rb=%b fv=%b len=%0d sc=%h ov=%0d",
               idx, wr_en, wr_addr, wr_data, rd_bank, fv, flen, fsc, ovr,
               v.wen, v.wa, v.wd, v.rb, v.fv, v.len, v.sc, v.ov);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_wen"}, {31'd0, wr_en}, 32'd0);
    chk({name, "_wa"},  {22'd0, wr_addr}, 32'd0);
    chk({name, "_wd"},  {24'd0, wr_data}, 32'd0);
    chk({name, "_pub"}, {12'd0, rd_bank, fv, flen, fsc}, 32'd0);
    chk({name, "_ov"},  {24'd0, ovr}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt;
    brk_det = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_ferr = 1'b0; frame_ack = 1'b0;

    e_rb = 1'b0; e_fv = 1'b0; e_len = 10'd0; e_sc = 8'h00; e_ov = 8'h00;
    // full 12-slot frame into bank 1
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    for (int i = 0; i < 12; i++) push(0, 1, 8'(i), 0, 0, 1, 10'h200 + 10'(i), 8'(i));
    push(0, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    e_rb = 1'b1; e_fv = 1'b1; e_len = 10'd12;
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    // second frame without ack: overrun, bank 0 reused
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    for (int i = 0; i < 3; i++) push(0, 1, 8'h30 + 8'(i), 0, 0, 1, 10'h000 + 10'(i), 8'h30 + 8'(i));
    e_ov = 8'd1;
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    // ack coincident with commit
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    for (int i = 0; i < 2; i++) push(0, 1, 8'h40 + 8'(i), 0, 0, 1, 10'h000 + 10'(i), 8'h40 + 8'(i));
    e_rb = 1'b0; e_len = 10'd2;
    push(1, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    // ack alone, then ack with nothing published
    e_fv = 1'b0;
    push(0, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    push(0, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    // non-zero start code
    push(0, 1, 8'hCC, 0, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h55, 0, 0, C_ALT, 10'h200, 8'h55);
    push(0, 1, 8'h56, 0, 0, C_ALT, 10'h201, 8'h56);
    if (C_ALT) begin e_rb = 1'b1; e_fv = 1'b1; e_sc = 8'hCC; end
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    e_fv = 1'b0;
    push(0, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    // start code only
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    e_rb = ~e_rb; e_fv = 1'b1; e_len = 10'd0; e_sc = 8'h00;
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    e_fv = 1'b0;
    push(0, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    // break and byte together: break wins
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    e_rb = ~e_rb; e_fv = 1'b1;
    push(1, 1, 8'h77, 0, 0, 0, 10'h000, 8'h00);
    e_fv = 1'b0;
    push(0, 0, 8'h00, 0, 1, 0, 10'h000, 8'h00);
    // framing error after 5 slots
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    for (int i = 0; i < 5; i++) push(0, 1, 8'hA0 + 8'(i), 0, 0, 1, {~e_rb, 9'(i)}, 8'hA0 + 8'(i));
    e_rb = ~e_rb; e_fv = 1'b1; e_len = 10'd5;
    push(0, 1, 8'hA5, 1, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h11, 0, 0, 0, 10'h000, 8'h00);
    push(1, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h00, 1, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    push(0, 1, 8'h12, 0, 0, 0, 10'h000, 8'h00);

    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].brk, tbl[i].rxv, tbl[i].d, tbl[i].ferr, tbl[i].ack);
      check_vec(i, tbl[i]);
    end

    // overrun counter saturation; published frame stays the 5-slot one
    drive(1, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 260; k++) begin
      drive(0, 1, 8'h00, 0, 0);
      drive(1, 0, 8'h00, 0, 0);
      if (k == 253) chk("ovr_254", {24'd0, ovr}, 32'd254);
    end
    chk("ovr_sat", {24'd0, ovr}, 32'd255);
    chk("ovr_pub", {21'd0, fv, flen}, {21'd0, 1'b1, 10'd5});

    // asynchronous reset during slot 3
    drive(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'(i), 0, 0);
    chk("pre_rst_wen", {31'd0, wr_en}, 32'd1);
    rx_valid = 1'b1; rx_data = 8'h03;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(0, 1, 8'h00, 0, 0);
    drive(0, 1, 8'h05, 0, 0);
    chk("post_rst_nobrk", {31'd0, wr_en}, 32'd0);
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h00, 0, 0);
    drive(0, 1, 8'hE0, 0, 0);
    chk("post_rst_w0", {23'd0, wr_en, wr_addr}, {23'd0, 1'b1, 10'h200});
    drive(0, 1, 8'hE1, 0, 0);
    chk("post_rst_w1", {15'd0, wr_en, wr_addr, wr_data}, {15'd0, 1'b1, 10'h201, 8'hE1});
    drive(1, 0, 8'h00, 0, 0);
    chk("post_rst_pub", {20'd0, rd_bank, fv, flen}, {20'd0, 1'b1, 1'b1, 10'd2});

    // MAX_SLOTS=8 instance receives 12 slots
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h00, 0, 0);
    wcnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 8'h60 + 8'(i), 0, 0);
      if (wr_en8) wcnt++;
      if (i == 7) chk("max_last_wr", {14'd0, wr_addr8, wr_data8}, {14'd0, 10'h207, 8'h67});
    end
    chk("max_wr_count", wcnt, 32'd8);
    drive(1, 0, 8'h00, 0, 0);
    chk("max_len", {21'd0, fv8, flen8}, {21'd0, 1'b1, 10'd8});
    chk("full_len", {21'd0, fv, flen}, {21'd0, 1'b1, 10'd12});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
